// File: rtl/exmem_pkg.sv
// Shared widths, control-bit positions and occupancy states for the EX/MEM skid stage.
package exmem_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_REG_W  = 5;
  localparam int unsigned DEF_WB_W   = 2;
  localparam int unsigned DEF_M_W    = 2;

  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned M_MEMWRITE  = 1;
  localparam int unsigned M_MEMREAD   = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/skid_buf.sv
// Generic two-entry valid/ready skid buffer with synchronous flush.
// The head entry lives in main_q; skid_q absorbs one extra entry under back-pressure.
module skid_buf
  import exmem_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  state_e state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic in_ready_q;
  logic push, pop;

  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign in_ready  = in_ready_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // A pop in this cycle has already been taken by MEM; any push is dropped.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (push) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != FULL);
    end
  end

endmodule

// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline stage: packs the EX outputs into a skid buffer, gates control
// outputs by head validity and exposes a forwarding tap for the hazard unit.
module ex_mem_skid_stage
  import exmem_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned REG_W  = DEF_REG_W,
  parameter int unsigned WB_W   = DEF_WB_W,
  parameter int unsigned M_W    = DEF_M_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   wb_in,
  input  logic [M_W-1:0]    m_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic [DATA_W-1:0] store_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              mem_write,
  output logic              mem_read,
  output logic [WB_W-1:0]   wb_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [REG_W-1:0]  rd_out,
  output logic [DATA_W-1:0] store_out,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_rd,
  output logic [DATA_W-1:0] fwd_data
);

  localparam int unsigned W = WB_W + M_W + REG_W + 2 * DATA_W;

  logic [W-1:0]      in_data, out_data;
  logic [WB_W-1:0]   wb_h;
  logic [M_W-1:0]    m_h;
  logic [REG_W-1:0]  rd_h;
  logic [DATA_W-1:0] alu_h, store_h;

  assign in_data = {wb_in, m_in, rd_in, alu_in, store_in};

  skid_buf #(
    .W(W)
  ) u_skid_buf (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  assign {wb_h, m_h, rd_h, alu_h, store_h} = out_data;

  // Control is squashed when invalid; data fields simply hold their last value.
  assign mem_write = out_valid & m_h[M_MEMWRITE];
  assign mem_read  = out_valid & m_h[M_MEMREAD];
  assign wb_out    = out_valid ? wb_h : '0;
  assign alu_out   = alu_h;
  assign rd_out    = rd_h;
  assign store_out = store_h;

  assign fwd_valid = out_valid & wb_h[WB_REGWRITE] & (rd_h != '0);
  assign fwd_rd    = rd_h;
  assign fwd_data  = alu_h;

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Directed and randomized checks of ex_mem_skid_stage against a queue-based model.
module tb_ex_mem_skid_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [1:0]  wb_in, m_in;
  logic [31:0] alu_in, store_in;
  logic [4:0]  rd_in;
  logic        flush;
  logic        out_valid, out_ready;
  logic        mem_write, mem_read;
  logic [1:0]  wb_out;
  logic [31:0] alu_out, store_out;
  logic [4:0]  rd_out;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;

  always #5 clk = ~clk;

  ex_mem_skid_stage dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wb_in    (wb_in),
    .m_in     (m_in),
    .alu_in   (alu_in),
    .rd_in    (rd_in),
    .store_in (store_in),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .mem_write(mem_write),
    .mem_read (mem_read),
    .wb_out   (wb_out),
    .alu_out  (alu_out),
    .rd_out   (rd_out),
    .store_out(store_out),
    .fwd_valid(fwd_valid),
    .fwd_rd   (fwd_rd),
    .fwd_data (fwd_data)
  );

  typedef struct packed {
    logic [1:0]  wb;
    logic [1:0]  m;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] st;
  } ent_t;

  ent_t q[$];
  ent_t last;
  logic exp_rdy;
  int   passed = 0;
  int   total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all();
    logic v;
    v = (q.size() > 0);
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    check("out_valid", 64'(out_valid), 64'(v));
    check("mem_write", 64'(mem_write), 64'(v & last.m[1]));
    check("mem_read", 64'(mem_read), 64'(v & last.m[0]));
    check("wb_out", 64'(wb_out), v ? 64'(last.wb) : 64'd0);
    check("alu_out", 64'(alu_out), 64'(last.alu));
    check("rd_out", 64'(rd_out), 64'(last.rd));
    check("store_out", 64'(store_out), 64'(last.st));
    check("fwd_valid", 64'(fwd_valid), 64'(v && last.wb[1] && last.rd != 5'd0));
    check("fwd_rd", 64'(fwd_rd), 64'(last.rd));
    check("fwd_data", 64'(fwd_data), 64'(last.alu));
  endtask

  // Drive one cycle of inputs, advance the model, then sample just after the edge.
  task automatic tick(input logic v, input ent_t e, input logic ordy, input logic fl);
    logic push, pop;
    in_valid  = v;
    wb_in     = e.wb;
    m_in      = e.m;
    rd_in     = e.rd;
    alu_in    = e.alu;
    store_in  = e.st;
    out_ready = ordy;
    flush     = fl;
    push = v & exp_rdy;
    pop  = (q.size() > 0) & ordy;
    if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
    end
    if (q.size() > 0) last = q[0];
    exp_rdy = (q.size() < 2);
    @(posedge clk);
    #1;
    check_all();
  endtask

  function automatic ent_t mk(input logic [1:0] wb, input logic [1:0] m, input logic [4:0] rd,
                              input logic [31:0] alu, input logic [31:0] st);
    ent_t e;
    e.wb = wb; e.m = m; e.rd = rd; e.alu = alu; e.st = st;
    return e;
  endfunction

  initial begin
    ent_t z, e;
    z = '0;
    reset = 1'b1;
    in_valid = 0; wb_in = 0; m_in = 0; rd_in = 0; alu_in = 0; store_in = 0;
    flush = 0; out_ready = 0;
    last = '0;
    exp_rdy = 1'b1;
    #12;
    check_all();
    reset = 1'b0;

    // Single push with immediate drain
    tick(1, mk(2'b10, 2'b00, 5'd5, 32'h10, 32'h0), 1, 0);
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_alu", 64'(alu_out), 64'h10);
    check("single_fwd_valid", 64'(fwd_valid), 64'd1);
    check("single_fwd_rd", 64'(fwd_rd), 64'd5);
    tick(0, z, 1, 0);
    check("single_drained", 64'(out_valid), 64'd0);

    // Back-to-back A, B, C
    tick(1, mk(2'b10, 2'b00, 5'd1, 32'hA, 32'h1), 1, 0);
    tick(1, mk(2'b11, 2'b01, 5'd2, 32'hB, 32'h2), 1, 0);
    check("b2b_A_gone", 64'(alu_out), 64'hB);
    tick(1, mk(2'b00, 2'b10, 5'd3, 32'hC, 32'h3), 1, 0);
    check("b2b_in_ready", 64'(in_ready), 64'd1);
    tick(0, z, 1, 0);

    // Back-pressure fills the skid entry
    tick(1, mk(2'b10, 2'b00, 5'd4, 32'h100, 32'h0), 0, 0);
    tick(1, mk(2'b10, 2'b00, 5'd6, 32'h200, 32'h0), 0, 0);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    tick(0, z, 1, 0);
    check("bp_second_head", 64'(alu_out), 64'h200);
    check("bp_in_ready_back", 64'(in_ready), 64'd1);
    tick(0, z, 1, 0);

    // Flush while FULL with a store at head, concurrent push discarded
    tick(1, mk(2'b00, 2'b10, 5'd7, 32'h300, 32'hDEAD), 0, 0);
    tick(1, mk(2'b10, 2'b00, 5'd8, 32'h400, 32'hBEEF), 0, 0);
    check("pre_flush_mem_write", 64'(mem_write), 64'd1);
    tick(1, mk(2'b10, 2'b01, 5'd9, 32'h500, 32'h0), 0, 1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_mem_write", 64'(mem_write), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    tick(0, z, 1, 0);
    check("flush_push_absent", 64'(out_valid), 64'd0);

    // rd = 0 never forwards; mem_read only while valid
    tick(1, mk(2'b10, 2'b00, 5'd0, 32'h600, 32'h0), 0, 0);
    check("rd0_fwd_valid", 64'(fwd_valid), 64'd0);
    tick(0, z, 1, 0);
    tick(1, mk(2'b00, 2'b01, 5'd3, 32'h700, 32'h0), 0, 0);
    check("mem_read_valid", 64'(mem_read), 64'd1);
    tick(0, z, 1, 0);
    check("mem_read_idle", 64'(mem_read), 64'd0);

    // Asynchronous reset while FULL
    tick(1, mk(2'b11, 2'b11, 5'd10, 32'h800, 32'h1), 0, 0);
    tick(1, mk(2'b11, 2'b11, 5'd11, 32'h900, 32'h2), 0, 0);
    #2;
    reset = 1'b1;
    #1;
    q.delete();
    last = '0;
    exp_rdy = 1'b1;
    check_all();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      e = mk(2'($urandom), 2'($urandom), 5'($urandom), $urandom, $urandom);
      tick($urandom_range(0, 3) != 0, e, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid_stage.md
# ex_mem_skid_stage

Parametrised EX→MEM pipeline stage with valid/ready handshake and a two-entry skid buffer. It carries the WB/M control fields, ALU result, destination register and store data, and supports back-pressure from MEM, synchronous flush with bubble insertion, and a forwarding tap for the hazard unit. It sits between the execute stage and the data-memory stage and replaces the fixed, always-advancing EX/MEM register.

## Interface
- DATA_W, 32, width of ALU result and store data
- REG_W, 5, destination register index width
- WB_W, 2, write-back control width; bit 1 = RegWrite
- M_W, 2, memory control width; bit 1 = MemWrite, bit 0 = MemRead

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  EX presents a valid entry
- in_ready  out  1  stage can accept; registered
- wb_in  in  WB_W  write-back control
- m_in  in  M_W  memory control
- alu_in  in  DATA_W  ALU result / address
- rd_in  in  REG_W  destination register
- store_in  in  DATA_W  store data (rs2 value)
- flush  in  1  synchronous squash of all held entries
- out_valid  out  1  head entry valid
- out_ready  in  1  MEM accepts head entry
- mem_write  out  1  M[1] of head, 0 when !out_valid
- mem_read  out  1  M[0] of head, 0 when !out_valid
- wb_out  out  WB_W  head WB field, 0 when !out_valid
- alu_out  out  DATA_W  head ALU result
- rd_out  out  REG_W  head destination register
- store_out  out  DATA_W  head store data
- fwd_valid  out  1  out_valid & wb_out[1] & (rd_out != 0)
- fwd_rd  out  REG_W  equals rd_out
- fwd_data  out  DATA_W  equals alu_out

## Operation
- push = in_valid & in_ready; pop = out_valid & out_ready.
- Storage: main register (head, drives outputs) and skid register.
- States: EMPTY, ONE, FULL.
  - EMPTY: push → ONE (main ← input).
  - ONE: push & pop → ONE (main ← input); push only → FULL (skid ← input); pop only → EMPTY.
  - FULL: no push possible; pop → ONE (main ← skid).
- in_ready = 1 in EMPTY and ONE, 0 in FULL; derived from next state, so it is a flop output.
- Order strictly preserved; no entry is duplicated or dropped except by flush.
- flush has priority over push/pop: next state EMPTY, both entries invalidated, control fields zeroed. An entry pushed in the flush cycle is discarded. A pop in the flush cycle still completes, because MEM sampled the head.
- Data fields (alu_out, rd_out, store_out) keep their last value when invalid. Only the control outputs are gated.

## Timing
- Latency: push into EMPTY → out_valid and fields valid on the next rising edge (1 cycle).
- Throughput: 1 entry/cycle while out_ready = 1.
- out_ready low with one entry held → next push fills skid, in_ready drops the following cycle; at most 2 entries held.
- Async reset: state EMPTY, in_ready = 1, out_valid = 0, mem_write = mem_read = 0, wb_out = 0, alu_out = store_out = 0, rd_out = 0, fwd_valid = 0. Reset asserted mid-operation discards all entries immediately.
- All outputs are registered or a function of registered state only; no combinational in→out path.

## Structure
- Package exmem_pkg: default widths, bit indices WB_REGWRITE = 1, M_MEMWRITE = 1, M_MEMREAD = 0, and the state enum {EMPTY, ONE, FULL}.
- Sub-module skid_buf #(W): generic 2-entry valid/ready skid buffer over a packed payload, with flush. The top packs {wb, m, rd, alu, store}, unpacks it, and applies output gating and forwarding logic.

## Test plan
- Reset then single push {wb=2'b10, m=2'b00, alu=32'h10, rd=5} with out_ready = 1 → next cycle out_valid = 1, alu_out = 32'h10, fwd_valid = 1, fwd_rd = 5; following cycle out_valid = 0.
- Back-to-back pushes A, B, C with out_ready = 1 → A, B, C appear on consecutive cycles, in_ready stays 1.
- out_ready = 0, push A then B → in_ready = 0 after B; raise out_ready → A then B drained in order, in_ready = 1 after first pop.
- FULL with store entry (m = 2'b10) at head, assert flush together with in_valid → next cycle out_valid = 0, mem_write = 0, in_ready = 1, pushed entry absent.
- Head with rd = 0, wb = 2'b10 → fwd_valid = 0. Head with m = 2'b01 → mem_read = 1 only while out_valid.
- Assert reset while FULL → immediately out_valid = 0, all control outputs 0, in_ready = 1.
